counter_step_controller: RTL and testbench

- Command-side initiator for the team's FSM up/down counter. Drives the counter's enable/ctrl inputs and monitors its count/overflow outputs.
- Accepts a target value over a valid/ready handshake and steps the counter one increment or decrement at a time until count equals the target.
- Reports completion, or latches a fault on overflow, stall timeout, or a wrong or illegal step.
- Sits between the control/config logic and the counter instance.

---
 rtl/counter_step_controller.sv | 206 ++++++++++++++++++++
 tb/tb_counter_step_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_step_controller.sv
// counter_step_controller
// Command-side initiator for the up/down counter: accepts a target count,
// walks the counter towards it one enable pulse at a time, and reports
// completion or a latched fault (overflow, stall timeout, bad step).
// All outputs are registered or decoded from the state register.

module counter_step_controller #(
    parameter int WIDTH    = 4,
    parameter int WAIT_MAX = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [WIDTH-1:0] i_cmd_target,
    input  logic             i_cmd_abort,
    input  logic             i_fault_clr,
    output logic             o_cnt_enable,
    output logic             o_cnt_ctrl,
    input  logic [WIDTH-1:0] i_cnt_count,
    input  logic             i_cnt_overflow,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_fault,
    output logic [1:0]       o_err_code,
    output logic [WIDTH:0]   o_step_count
);

    // Wait counter wide enough to reach WAIT_MAX-1 (at least one bit).
    localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_BADSTEP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_STEP,
        S_WAIT,
        S_FAULT
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_prev;
    logic             r_ctrl;
    logic [WIDTH:0]   r_step_count;
    logic [WW-1:0]    r_wait;
    logic [1:0]       r_err_code;
    logic             r_done;

    logic [WIDTH-1:0] w_expected;
    logic             w_match;
    logic             w_up;
    logic             w_good_step;
    logic             w_moved;
    logic             w_wait_expired;
    logic [1:0]       w_fault_code;
    logic             w_finish;

    // Compare helpers: target match, direction, and what the counter did since the step.
    always_comb begin
        w_expected     = r_ctrl ? (r_prev + 1'b1) : (r_prev - 1'b1);
        w_match        = (i_cnt_count == r_target);
        w_up           = (r_target > i_cnt_count);
        w_good_step    = (i_cnt_count == w_expected);
        w_moved        = (i_cnt_count != r_prev);
        w_wait_expired = (r_wait == WAIT_LAST);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort outranks overflow, which outranks match/step/timeout.
    always_comb begin
        w_next_state = r_state;
        w_fault_code = ERR_NONE;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (i_cmd_abort) begin
                    w_next_state = S_IDLE;
                end else if (i_cnt_overflow) begin
                    w_next_state = S_FAULT;
                    w_fault_code = ERR_OVERFLOW;
                end else if (w_match) begin
                    w_next_state = S_IDLE;
                    w_finish     = 1'b1;
                end else begin
                    w_next_state = S_STEP;
                end
            end
            S_STEP: begin
                if (i_cmd_abort) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_cmd_abort) begin
                    w_next_state = S_IDLE;
                end else if (i_cnt_overflow) begin
                    w_next_state = S_FAULT;
                    w_fault_code = ERR_OVERFLOW;
                end else if (w_good_step) begin
                    w_next_state = S_CHECK;
                end else if (w_moved) begin
                    w_next_state = S_FAULT;
                    w_fault_code = ERR_BADSTEP;
                end else if (w_wait_expired) begin
                    w_next_state = S_FAULT;
                    w_fault_code = ERR_TIMEOUT;
                end
            end
            S_FAULT: begin
                if (i_fault_clr) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Command datapath: latched target, direction, step bookkeeping, error code and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_target     <= '0;
            r_prev       <= '0;
            r_ctrl       <= 1'b0;
            r_step_count <= '0;
            r_wait       <= '0;
            r_err_code   <= ERR_NONE;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_finish;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_target     <= i_cmd_target;
                        r_step_count <= '0;
                    end
                end
                S_CHECK: begin
                    if (w_next_state == S_STEP) begin
                        r_ctrl <= w_up;
                    end
                end
                S_STEP: begin
                    // The enable pulse is already on the wire this cycle, so the
                    // step is counted even when an abort cuts the command short.
                    r_step_count <= r_step_count + 1'b1;
                    r_prev       <= i_cnt_count;
                    r_wait       <= '0;
                end
                S_WAIT: begin
                    if (!w_wait_expired) begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_FAULT: begin
                    if (i_fault_clr) begin
                        r_err_code <= ERR_NONE;
                    end
                end
                default: begin
                    r_wait <= '0;
                end
            endcase
            if ((r_state != S_FAULT) && (w_next_state == S_FAULT)) begin
                r_err_code <= w_fault_code;
            end
        end
    end

    // Output decode from the state register and datapath registers.
    always_comb begin
        o_cmd_ready  = (r_state == S_IDLE);
        o_cnt_enable = (r_state == S_STEP);
        o_busy       = (r_state == S_CHECK) || (r_state == S_STEP) || (r_state == S_WAIT);
        o_fault      = (r_state == S_FAULT);
        o_cnt_ctrl   = r_ctrl;
        o_done       = r_done;
        o_err_code   = r_err_code;
        o_step_count = r_step_count;
    end

endmodule

// File: tb/tb_counter_step_controller.sv
// tb_counter_step_controller
// Directed bench for counter_step_controller with a behavioural up/down
// counter model (1-cycle update) that can be preset, frozen or made to skip.

module tb_counter_step_controller;

    localparam int WIDTH    = 4;
    localparam int WAIT_MAX = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_cmd_valid;
    logic             o_cmd_ready;
    logic [WIDTH-1:0] i_cmd_target;
    logic             i_cmd_abort;
    logic             i_fault_clr;
    logic             o_cnt_enable;
    logic             o_cnt_ctrl;
    logic             i_cnt_overflow;
    logic             o_busy;
    logic             o_done;
    logic             o_fault;
    logic [1:0]       o_err_code;
    logic [WIDTH:0]   o_step_count;

    logic [WIDTH-1:0] modelCount = '0;
    logic             loadEn = 1'b0;
    logic [WIDTH-1:0] loadVal = '0;
    logic             frozen = 1'b0;
    logic             jump = 1'b0;

    int pulseTotal = 0;
    int doubleEn = 0;
    logic prevEn = 1'b0;

    int checks = 0;
    int failures = 0;

    counter_step_controller #(.WIDTH(WIDTH), .WAIT_MAX(WAIT_MAX)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_target  (i_cmd_target),
        .i_cmd_abort   (i_cmd_abort),
        .i_fault_clr   (i_fault_clr),
        .o_cnt_enable  (o_cnt_enable),
        .o_cnt_ctrl    (o_cnt_ctrl),
        .i_cnt_count   (modelCount),
        .i_cnt_overflow(i_cnt_overflow),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_fault       (o_fault),
        .o_err_code    (o_err_code),
        .o_step_count  (o_step_count)
    );

    always #5 clk = ~clk;

    // Counter model: preset load, otherwise one step per enable unless frozen; jump skips by two going up.
    always @(posedge clk) begin
        if (loadEn) begin
            modelCount <= loadVal;
        end else if (o_cnt_enable && !frozen) begin
            if (o_cnt_ctrl) begin
                modelCount <= jump ? modelCount + 4'd2 : modelCount + 4'd1;
            end else begin
                modelCount <= modelCount - 4'd1;
            end
        end
    end

    // Enable pulse bookkeeping: total pulses and back-to-back enable occurrences.
    always @(posedge clk) begin
        if (o_cnt_enable) pulseTotal <= pulseTotal + 1;
        if (o_cnt_enable && prevEn) doubleEn <= doubleEn + 1;
        prevEn <= o_cnt_enable;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] target);
        i_cmd_valid  = valid;
        i_cmd_target = target;
    endtask

    task automatic presetCount(input logic [WIDTH-1:0] v);
        loadEn  = 1'b1;
        loadVal = v;
        @(negedge clk);
        loadEn  = 1'b0;
    endtask

    // Issues a command for one cycle; returns at the negedge of the cycle after acceptance.
    task automatic issueCommand(input logic [WIDTH-1:0] target, output int pulseStart);
        applyStimulus(1'b1, target);
        pulseStart = pulseTotal;
        @(negedge clk);
        applyStimulus(1'b0, '0);
    endtask

    task automatic waitDone(output int k);
        k = 1;
        while (o_done !== 1'b1 && k < 80) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic waitFault(output int k);
        k = 1;
        while (o_fault !== 1'b1 && k < 80) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'(o_cmd_ready), 32'd1);
        checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
        checkOutput({tag, "_enable"}, 32'(o_cnt_enable), 32'd0);
        checkOutput({tag, "_ctrl"}, 32'(o_cnt_ctrl), 32'd0);
        checkOutput({tag, "_done"}, 32'(o_done), 32'd0);
        checkOutput({tag, "_fault"}, 32'(o_fault), 32'd0);
        checkOutput({tag, "_err"}, 32'(o_err_code), 32'd0);
        checkOutput({tag, "_steps"}, 32'(o_step_count), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int p0;

        reset          = 1'b1;
        i_cmd_valid    = 1'b0;
        i_cmd_target   = '0;
        i_cmd_abort    = 1'b0;
        i_fault_clr    = 1'b0;
        i_cnt_overflow = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkResetValues("rst");

        // 3 -> 6: up, three pulses, done 11 cycles after accept
        presetCount(4'd3);
        issueCommand(4'd6, p0);
        waitDone(k);
        checkOutput("up_done", 32'(o_done), 32'd1);
        checkOutput("up_latency", 32'(k), 32'd11);
        checkOutput("up_ctrl", 32'(o_cnt_ctrl), 32'd1);
        checkOutput("up_count", 32'(modelCount), 32'd6);
        checkOutput("up_steps", 32'(o_step_count), 32'd3);
        checkOutput("up_pulses", 32'(pulseTotal - p0), 32'd3);
        checkOutput("up_fault", 32'(o_fault), 32'd0);
        @(negedge clk);
        checkOutput("up_done_pulse", 32'(o_done), 32'd0);

        // 9 -> 4: down, five pulses, done 17 cycles after accept
        presetCount(4'd9);
        issueCommand(4'd4, p0);
        waitDone(k);
        checkOutput("dn_latency", 32'(k), 32'd17);
        checkOutput("dn_ctrl", 32'(o_cnt_ctrl), 32'd0);
        checkOutput("dn_count", 32'(modelCount), 32'd4);
        checkOutput("dn_steps", 32'(o_step_count), 32'd5);
        checkOutput("dn_pulses", 32'(pulseTotal - p0), 32'd5);

        // 7 -> 7: already there, done 2 cycles after accept
        presetCount(4'd7);
        issueCommand(4'd7, p0);
        waitDone(k);
        checkOutput("eq_latency", 32'(k), 32'd2);
        checkOutput("eq_steps", 32'(o_step_count), 32'd0);
        checkOutput("eq_pulses", 32'(pulseTotal - p0), 32'd0);

        // Frozen counter: timeout after WAIT_MAX cycles in WAIT
        presetCount(4'd2);
        frozen = 1'b1;
        issueCommand(4'd5, p0);
        waitFault(k);
        checkOutput("to_latency", 32'(k), 32'(3 + WAIT_MAX));
        checkOutput("to_err", 32'(o_err_code), 32'd2);
        checkOutput("to_ready", 32'(o_cmd_ready), 32'd0);
        @(negedge clk);
        checkOutput("to_fault_held", 32'(o_fault), 32'd1);
        checkOutput("to_ready_held", 32'(o_cmd_ready), 32'd0);
        i_fault_clr = 1'b1;
        applyStimulus(1'b1, 4'd9);
        @(negedge clk);
        i_fault_clr = 1'b0;
        applyStimulus(1'b0, '0);
        checkOutput("clr_fault", 32'(o_fault), 32'd0);
        checkOutput("clr_err", 32'(o_err_code), 32'd0);
        checkOutput("clr_ready", 32'(o_cmd_ready), 32'd1);
        @(negedge clk);
        checkOutput("clr_no_accept", 32'(o_busy), 32'd0);

        // Overflow forced while in WAIT
        issueCommand(4'd5, p0);
        repeat (2) @(negedge clk);
        checkOutput("ovf_in_wait", 32'(o_busy), 32'd1);
        i_cnt_overflow = 1'b1;
        @(negedge clk);
        i_cnt_overflow = 1'b0;
        checkOutput("ovf_fault", 32'(o_fault), 32'd1);
        checkOutput("ovf_err", 32'(o_err_code), 32'd1);
        i_fault_clr = 1'b1;
        @(negedge clk);
        i_fault_clr = 1'b0;
        frozen = 1'b0;

        // Counter skips 2 -> 4: bad step
        presetCount(4'd2);
        jump = 1'b1;
        issueCommand(4'd5, p0);
        repeat (3) @(negedge clk);
        checkOutput("bad_fault", 32'(o_fault), 32'd1);
        checkOutput("bad_err", 32'(o_err_code), 32'd3);
        i_fault_clr = 1'b1;
        @(negedge clk);
        i_fault_clr = 1'b0;
        jump = 1'b0;

        // Abort during the second STEP of 3 -> 8
        presetCount(4'd3);
        issueCommand(4'd8, p0);
        repeat (4) @(negedge clk);
        checkOutput("ab_second_step", 32'(o_cnt_enable), 32'd1);
        i_cmd_abort = 1'b1;
        @(negedge clk);
        i_cmd_abort = 1'b0;
        checkOutput("ab_enable", 32'(o_cnt_enable), 32'd0);
        checkOutput("ab_idle", 32'(o_cmd_ready), 32'd1);
        checkOutput("ab_done", 32'(o_done), 32'd0);
        checkOutput("ab_steps", 32'(o_step_count), 32'd2);
        checkOutput("ab_count", 32'(modelCount), 32'd5);
        @(negedge clk);
        checkOutput("ab_done_late", 32'(o_done), 32'd0);

        // Reset asserted while in WAIT
        presetCount(4'd3);
        issueCommand(4'd8, p0);
        repeat (2) @(negedge clk);
        checkOutput("rw_in_wait", 32'(o_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkResetValues("rw");

        checkOutput("no_double_enable", 32'(doubleEn), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
